// File: rtl/slt_seq_if.sv
// slt_seq_if: request/response handshake bundle for the sequential set-less-than engine.
interface slt_seq_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             aluc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             negative;
  logic             busy;
  modport master (
    output req_valid, a, b, aluc, rsp_ready,
    input  req_ready, rsp_valid, c, carry, negative, busy
  );
  modport slave (
    input  req_valid, a, b, aluc, rsp_ready,
    output req_ready, rsp_valid, c, carry, negative, busy
  );
endinterface

// File: rtl/slt_seq.sv
// slt_seq: multi-cycle MSB-first set-less-than engine, DIGIT bits per cycle,
// signed and unsigned orderings resolved in parallel behind a valid/ready handshake.
module slt_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic        clk,
  input logic        rst_n,
  slt_seq_if.slave   bus
);
  localparam int NS = WIDTH / DIGIT;
  localparam int CW = NS > 1 ? $clog2(NS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             aluc_q, aluc_d;
  logic             dec_u_q, dec_u_d, dec_s_q, dec_s_d;
  logic             lt_u_q, lt_u_d, lt_s_q, lt_s_d;
  logic             carry_q, carry_d, neg_q, neg_d, c0_q, c0_d;
  logic [DIGIT-1:0] sa, sb, flip, ssa, ssb;
  always_comb begin
    sa = a_q[WIDTH-1 -: DIGIT];
    sb = b_q[WIDTH-1 -: DIGIT];
    flip = '0;
    flip[DIGIT-1] = cnt_q == '0;
    ssa = sa ^ flip;
    ssb = sb ^ flip;
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    aluc_d = aluc_q;
    dec_u_d = dec_u_q;
    dec_s_d = dec_s_q;
    lt_u_d = lt_u_q;
    lt_s_d = lt_s_q;
    carry_d = carry_q;
    neg_d = neg_q;
    c0_d = c0_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        a_d = bus.a;
        b_d = bus.b;
        aluc_d = bus.aluc;
        cnt_d = '0;
        dec_u_d = 1'b0;
        dec_s_d = 1'b0;
        lt_u_d = 1'b0;
        lt_s_d = 1'b0;
        state_d = SCAN;
      end
      SCAN: begin
        // operands shift up so the slice under test always sits at the top
        a_d = a_q << DIGIT;
        b_d = b_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (!dec_u_q && sa != sb) begin
          dec_u_d = 1'b1;
          lt_u_d = sa < sb;
        end
        if (!dec_s_q && ssa != ssb) begin
          dec_s_d = 1'b1;
          lt_s_d = ssa < ssb;
        end
        if (cnt_q == CW'(NS - 1)) begin
          carry_d = lt_u_d;
          neg_d = lt_s_d;
          c0_d = aluc_q ? lt_u_d : lt_s_d;
          state_d = DONE;
        end
      end
      DONE: state_d = bus.rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      aluc_q <= 1'b0;
      dec_u_q <= 1'b0;
      dec_s_q <= 1'b0;
      lt_u_q <= 1'b0;
      lt_s_q <= 1'b0;
      carry_q <= 1'b0;
      neg_q <= 1'b0;
      c0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      aluc_q <= aluc_d;
      dec_u_q <= dec_u_d;
      dec_s_q <= dec_s_d;
      lt_u_q <= lt_u_d;
      lt_s_q <= lt_s_d;
      carry_q <= carry_d;
      neg_q <= neg_d;
      c0_q <= c0_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.c = {{(WIDTH - 1){1'b0}}, c0_q};
  assign bus.carry = carry_q;
  assign bus.negative = neg_q;
endmodule

// File: tb/tb_slt_seq.sv
// tb_slt_seq: directed and randomized checks of slt_seq against an arithmetic set-less-than model.
module tb_slt_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  slt_seq_if #(.WIDTH(32)) bus ();
  slt_seq #(.WIDTH(32), .DIGIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_req(input logic [31:0] ta, input logic [31:0] tb_, input logic tal, input int gap);
    int n;
    logic ec, en;
    logic [31:0] ecv;
    ec = ta < tb_;
    en = $signed(ta) < $signed(tb_);
    ecv = {31'd0, tal ? ec : en};
    n = 0;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    chk("req_ready_before", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.a = ta;
    bus.b = tb_;
    bus.aluc = tal;
    step();
    bus.req_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.aluc = ~tal;
    chk("busy_scan", {bus.busy, bus.req_ready}, 2'b10);
    n = 1;
    while (!bus.rsp_valid && n < 100) begin
      step();
      n++;
    end
    chk("latency", n, 9);
    for (int i = 0; i < gap; i++) begin
      bus.req_valid = 1'b1;
      bus.a = $urandom;
      bus.b = $urandom;
      step();
      chk("hold_hs", {bus.rsp_valid, bus.req_ready}, 2'b10);
      chk("hold_c", bus.c, ecv);
    end
    bus.req_valid = 1'b0;
    chk("c", bus.c, ecv);
    chk("carry", bus.carry, ec);
    chk("negative", bus.negative, en);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("idle_after", {bus.req_ready, bus.rsp_valid, bus.busy}, 3'b100);
    chk("c_retained", {bus.c[0], bus.carry, bus.negative}, {ecv[0], ec, en});
  endtask
  initial begin
    logic [31:0] ra, rb, rr;
    int k;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.aluc = 1'b0;
    step();
    step();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_flags", {bus.carry, bus.negative}, 2'b00);
    rst_n = 1'b1;
    step();
    run_req(32'hFFFFFFFE, 32'h00000001, 1'b1, 0);
    run_req(32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
    // abort a scan in its third cycle; the previous result must be wiped
    bus.req_valid = 1'b1;
    bus.a = 32'h00000001;
    bus.b = 32'hFFFFFFFF;
    bus.aluc = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_hs", {bus.rsp_valid, bus.req_ready, bus.busy}, 3'b010);
    chk("midrst_c", bus.c, 0);
    chk("midrst_flags", {bus.carry, bus.negative}, 2'b00);
    step();
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.rsp_valid) k++;
    end
    chk("no_rsp_after_rst", k, 0);
    run_req(32'h00000001, 32'hFFFFFFFF, 1'b1, 0);
    run_req(32'h80000000, 32'h80000000, 1'b0, 0);
    run_req(32'h7FFFFFFF, 32'h80000000, 1'b0, 0);
    run_req(32'h7FFFFFFF, 32'h80000000, 1'b1, 5);
    run_req(32'h00000005, 32'h00000006, 1'b0, 0);
    run_req(32'h00000005, 32'h00000006, 1'b1, 0);
    run_req(32'h00000006, 32'h00000005, 1'b1, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rr = $urandom;
      k = $urandom_range(0, 3);
      rb = k == 0 ? rr : k == 1 ? ra : k == 2 ? {ra[31:4], rr[3:0]} : ra ^ 32'h80000000;
      for (int j = $urandom_range(0, 2); j > 0; j--) step();
      run_req(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
